// File: rtl/cv32e40x_rvfi_pkg.sv
// Shared types for the RVFI retirement checker. This file holds the RVFI trap and
// interrupt sideband structs, the event record and kind encoding, the sticky error
// vector, the checker FSM states, and the helper that builds an event from one
// retirement.
package cv32e40x_rvfi_pkg;

   typedef struct packed {
      logic [1:0] cause_type;
      logic [2:0] debug_cause;
      logic [5:0] exception_cause;
      logic       debug;
      logic       exception;
      logic       trap;
   } rvfi_trap_t;

   typedef struct packed {
      logic [10:0] cause;
      logic        interrupt;
      logic        exception;
      logic        intr;
   } rvfi_intr_t;

   typedef enum logic [1:0] {
      EVT_EXC_TRAP   = 2'd0,
      EVT_DBG_TRAP   = 2'd1,
      EVT_INTR_ENTRY = 2'd2,
      EVT_EXC_ENTRY  = 2'd3
   } rvfi_evt_kind_e;

   typedef struct packed {
      logic [31:0]    order;
      logic [10:0]    cause;
      rvfi_evt_kind_e kind;
   } rvfi_evt_t;

   // Bit 0 is ORDER, bit 3 is OVERFLOW.
   typedef struct packed {
      logic overflow;
      logic intr_enc;
      logic pc;
      logic order;
   } rvfi_chk_err_t;

   typedef enum logic {
      CHK_IDLE  = 1'b0,
      CHK_TRACK = 1'b1
   } rvfi_chk_state_e;

   // Handler entry (intr) wins over a trap on the same retirement. A trap counts as
   // a debug trap only when it is not also an exception.
   function automatic rvfi_evt_t evt_from_retire(input logic [31:0] order,
                                                 input rvfi_intr_t  intr,
                                                 input rvfi_trap_t  trap);
      rvfi_evt_t evt;
      evt       = '0;
      evt.order = order;
      if (intr.intr) begin
         evt.kind  = intr.interrupt ? EVT_INTR_ENTRY : EVT_EXC_ENTRY;
         evt.cause = intr.cause;
      end else if (trap.debug && !trap.exception) begin
         evt.kind  = EVT_DBG_TRAP;
         evt.cause = 11'(trap.debug_cause);
      end else begin
         evt.kind  = EVT_EXC_TRAP;
         evt.cause = 11'(trap.exception_cause);
      end
      return evt;
   endfunction

endpackage

// File: rtl/cv32e40x_rvfi_checker_if.sv
// This interface bundles the checker's RVFI input bus and its event and status
// outputs. The master modport is the retirement source and event consumer. The
// slave modport is the checker side.
interface cv32e40x_rvfi_checker_if;
   import cv32e40x_rvfi_pkg::*;

   logic          rvfi_valid;
   logic [63:0]   rvfi_order;
   logic [31:0]   rvfi_pc_rdata;
   logic [31:0]   rvfi_pc_wdata;
   rvfi_trap_t    rvfi_trap;
   rvfi_intr_t    rvfi_intr;
   logic          clear;
   logic          evt_valid;
   logic          evt_ready;
   rvfi_evt_t     evt;
   logic [31:0]   retire_cnt;
   rvfi_chk_err_t err_code;
   logic          err;

   modport master (
      output rvfi_valid, rvfi_order, rvfi_pc_rdata, rvfi_pc_wdata, rvfi_trap, rvfi_intr,
             clear, evt_ready,
      input  evt_valid, evt, retire_cnt, err_code, err
   );

   modport slave (
      input  rvfi_valid, rvfi_order, rvfi_pc_rdata, rvfi_pc_wdata, rvfi_trap, rvfi_intr,
             clear, evt_ready,
      output evt_valid, evt, retire_cnt, err_code, err
   );

endinterface

// File: rtl/cv32e40x_rvfi_evt_fifo.sv
// This is the event FIFO for the RVFI checker. It has no bypass, so a pushed entry
// appears at the head one cycle later.
// A flush empties the FIFO. A push in the same cycle as a flush lands in the
// emptied FIFO.
// When the FIFO is full, a push is accepted only if a pop happens in the same cycle.
// The head output reads zero while the FIFO is empty.
module cv32e40x_rvfi_evt_fifo
   import cv32e40x_rvfi_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      i_push,
   input  logic      i_pop,
   input  logic      i_flush,
   input  rvfi_evt_t i_data,
   output rvfi_evt_t o_data,
   output logic      o_full,
   output logic      o_empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   rvfi_evt_t         r_mem [DEPTH];
   logic [AW-1:0]     r_rd_ptr;
   logic [AW-1:0]     r_wr_ptr;
   logic [CW-1:0]     r_count;

   logic              w_push_ok;
   logic              w_pop_ok;
   logic              w_wr_en;
   logic [AW-1:0]     w_wr_idx;

   assign o_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign w_pop_ok  = i_pop && !o_empty;
   assign w_push_ok = i_push && (!o_full || w_pop_ok);
   assign w_wr_en   = i_flush ? i_push : w_push_ok;
   assign w_wr_idx  = i_flush ? '0 : r_wr_ptr;
   assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

   // Pointer and occupancy bookkeeping; flush takes precedence over a pop.
   // NOTE: sequential state is written only with <= so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= i_push ? AW'(1) : '0;
         r_count  <= i_push ? CW'(1) : '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
      end
   end

   // Storage write.
   // NOTE: storage has no reset; the empty flag masks stale entries on the output.
   always_ff @(posedge clk) begin
      if (w_wr_en) r_mem[w_wr_idx] <= i_data;
   end

endmodule

// File: rtl/cv32e40x_rvfi_checker.sv
// The RVFI retirement checker runs the following checks on every retirement:
// - order is continuous across retirements;
// - the PC chains from one retirement to the next;
// - the interrupt sideband is encoded consistently.
// It queues trap and handler-entry events, counts retirements, and keeps sticky
// error bits. A clear wipes the errors, the counter and the queue. It does not
// touch the tracking state.
module cv32e40x_rvfi_checker
   import cv32e40x_rvfi_pkg::*;
#(
   parameter int EVT_DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          rvfi_valid_i,
   input  logic [63:0]   rvfi_order_i,
   input  logic [31:0]   rvfi_pc_rdata_i,
   input  logic [31:0]   rvfi_pc_wdata_i,
   input  rvfi_trap_t    rvfi_trap_i,
   input  rvfi_intr_t    rvfi_intr_i,
   input  logic          clear_i,
   output logic          evt_valid_o,
   input  logic          evt_ready_i,
   output rvfi_evt_t     evt_o,
   output logic [31:0]   retire_cnt_o,
   output rvfi_chk_err_t err_code_o,
   output logic          err_o
);

   rvfi_chk_state_e r_state;
   rvfi_chk_state_e w_state_next;
   logic [63:0]     r_prev_order;
   logic [31:0]     r_prev_pc;
   logic [31:0]     r_retire_cnt;
   rvfi_chk_err_t   r_err_code;
   rvfi_chk_err_t   w_new_err;

   logic            w_push;
   logic            w_pop;
   logic            w_full;
   logic            w_empty;
   rvfi_evt_t       w_evt;
   logic            w_unused_trap;

   assign w_push        = rvfi_valid_i && (rvfi_intr_i.intr || rvfi_trap_i.trap);
   assign w_pop         = evt_valid_o && evt_ready_i;
   assign w_evt         = evt_from_retire(rvfi_order_i[31:0], rvfi_intr_i, rvfi_trap_i);
   assign w_unused_trap = ^rvfi_trap_i.cause_type;

   cv32e40x_rvfi_evt_fifo #(
      .DEPTH (EVT_DEPTH)
   ) u_evt_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (clear_i),
      .i_data  (w_evt),
      .o_data  (evt_o),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign evt_valid_o  = !w_empty;
   assign retire_cnt_o = r_retire_cnt;
   assign err_code_o   = r_err_code;
   assign err_o        = |r_err_code;

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= CHK_IDLE;
      else        r_state <= w_state_next;
   end

   // FSM next state: leave IDLE on the first retirement, then stay in TRACK.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         CHK_IDLE:  if (rvfi_valid_i) w_state_next = CHK_TRACK;
         CHK_TRACK: w_state_next = CHK_TRACK;
         default:   w_state_next = CHK_IDLE;
      endcase
   end

   // Error conditions raised by the current retirement.
   always_comb begin
      w_new_err = '0;
      if (rvfi_valid_i) begin
         if (r_state == CHK_IDLE) w_new_err.order = (rvfi_order_i != 64'd1);
         else                     w_new_err.order = (rvfi_order_i != r_prev_order + 64'd1);
         w_new_err.pc = (r_state == CHK_TRACK) && !rvfi_intr_i.intr &&
                        (rvfi_pc_rdata_i != r_prev_pc);
         if (rvfi_intr_i.intr)
            w_new_err.intr_enc = !(rvfi_intr_i.interrupt ^ rvfi_intr_i.exception);
         else
            w_new_err.intr_enc = rvfi_intr_i.interrupt || rvfi_intr_i.exception ||
                                 (rvfi_intr_i.cause != '0);
      end
      w_new_err.overflow = w_push && w_full && !w_pop && !clear_i;
   end

   // Order and PC history; a clear leaves this history untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prev_order <= '0;
         r_prev_pc    <= '0;
      end else if (rvfi_valid_i) begin
         r_prev_order <= rvfi_order_i;
         r_prev_pc    <= rvfi_pc_wdata_i;
      end
   end

   // Saturating retirement counter; clear first, then count a coincident retirement.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                     r_retire_cnt <= '0;
      else if (clear_i)                               r_retire_cnt <= {31'd0, rvfi_valid_i};
      else if (rvfi_valid_i && (r_retire_cnt != '1))  r_retire_cnt <= r_retire_cnt + 32'd1;
   end

   // Sticky error bits; clear first, then record a coincident retirement's errors.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       r_err_code <= '0;
      else if (clear_i) r_err_code <= w_new_err;
      else              r_err_code <= rvfi_chk_err_t'(r_err_code | w_new_err);
   end

endmodule

// File: doc/cv32e40x_rvfi_checker.md
CV32E40X_RVFI_CHECKER -- requirements
Module: cv32e40x_rvfi_checker

Interface
REQ-001 SHALL have parameter: EVT_DEPTH, default 4, event FIFO depth (power of two, 2..16).
REQ-002 SHALL have ports, in this order:
- clk  input  1  core clock.
- rst_n  input  1  reset, asynchronous, active-low.
- rvfi_valid_i  input  1  retirement strobe.
- rvfi_order_i  input  64  retirement order.
- rvfi_pc_rdata_i  input  32  PC of the retired instruction.
- rvfi_pc_wdata_i  input  32  next PC.
- rvfi_trap_i  input  rvfi_trap_t  trap info.
- rvfi_intr_i  input  rvfi_intr_t  trap-handler entry info.
- clear_i  input  1  synchronous clear of errors, counter and FIFO.
- evt_valid_o  output  1  event available.
- evt_ready_i  input  1  event consumed.
- evt_o  output  rvfi_evt_t  head event: order[31:0], cause[10:0], kind[1:0].
- retire_cnt_o  output  32  retirements since reset or clear.
- err_code_o  output  rvfi_chk_err_t  sticky error bits: ORDER, PC, INTR_ENC, OVERFLOW.
- err_o  output  1  OR of err_code_o.

Function
REQ-003 SHALL contain a 2-state FSM:
- IDLE: no retirement seen; entered on reset.
- TRACK: entered on the first rvfi_valid_i; never left except by reset.
REQ-004 SHALL register the order and pc_wdata of every retirement as prev_order and prev_pc.
REQ-005 SHALL set ORDER when the first retirement in IDLE has order != 1.
REQ-006 SHALL set ORDER when a retirement in TRACK has order != prev_order+1, using 64-bit wrap-around arithmetic.
REQ-007 SHALL set PC when, in TRACK, pc_rdata != prev_pc and rvfi_intr_i.intr=0.
REQ-008 SHALL perform no PC check when rvfi_intr_i.intr=1 or in IDLE.
REQ-009 SHALL set INTR_ENC when intr=1 and interrupt+exception != 1.
REQ-010 SHALL set INTR_ENC when intr=0 and any of interrupt, exception or cause is nonzero.
REQ-011 SHALL update error bits at the clock edge ending the rvfi_valid_i cycle (visible 1 cycle later); bits are sticky.
REQ-012 SHALL push one event per retirement with rvfi_intr_i.intr=1 or rvfi_trap_i.trap=1.
REQ-013 SHALL give intr priority over trap when both are set on one retirement (single event).
REQ-014 SHALL encode event kind as:
- 2 = interrupt entry.
- 3 = exception entry.
- 0 = exception trap.
- 1 = debug trap.
REQ-015 SHALL set event cause from intr.cause for intr events and zero-extended trap.exception_cause for exception traps; debug trap cause = debug_cause.
REQ-016 SHALL pop the head event when evt_valid_o and evt_ready_i are both 1; evt_o SHALL be 0 when the FIFO is empty.
REQ-017 SHALL make a pushed event visible on evt_valid_o in the cycle after the push (no bypass).
REQ-018 SHALL drop a push to a full FIFO without a same-cycle pop and set OVERFLOW; a push and pop together when full SHALL succeed with no overflow.
REQ-019 SHALL increment retire_cnt_o per retirement and saturate at 0xFFFF_FFFF.
REQ-020 SHALL, on clear_i, zero err_code_o, flush the FIFO and zero retire_cnt_o; FSM state, prev_order and prev_pc are kept.
REQ-021 SHALL, when clear_i coincides with a retirement, apply the clear first: retire_cnt_o=1, that retirement's errors recorded, its event pushed into the emptied FIFO.

Reset
REQ-022 SHALL, on rst_n low, asynchronously force: FSM=IDLE, prev_order=0, prev_pc=0, FIFO empty, evt_valid_o=0, evt_o=0, retire_cnt_o=0, err_code_o=0, err_o=0.
REQ-023 SHALL discard any retirement in flight during reset; the first retirement after reset release SHALL be checked as the IDLE case.

Structure
REQ-024 SHALL declare rvfi_evt_t, rvfi_chk_err_t and the event-kind enum in cv32e40x_rvfi_pkg.
REQ-025 SHALL implement the event FIFO as sub-module cv32e40x_rvfi_evt_fifo (push, pop, flush, full, empty); the checks and the FSM stay in the top module.

Verification
REQ-026 SHALL cover order error: orders 1,2,3,5 -> ORDER set 1 cycle after order 5; retire_cnt_o=4.
REQ-027 SHALL cover PC error and its exemption:
- pc_wdata=0x100, next pc_rdata=0x104, intr=0 -> PC set.
- Same with intr=1, interrupt=1, cause=11 -> no PC error; event kind=2, cause=11.
REQ-028 SHALL cover bad interrupt encoding: intr=1 with interrupt=1 and exception=1 -> INTR_ENC set, err_o=1.
REQ-029 SHALL cover overflow: EVT_DEPTH=4, 5 trapping retirements, evt_ready_i=0 -> OVERFLOW set; then 4 pops return events in order; 5th event absent.
REQ-030 SHALL cover full-FIFO push+pop: FIFO full, push with evt_ready_i=1 -> no OVERFLOW; occupancy stays 4.
REQ-031 SHALL cover clear and reset mid-stream:
- clear_i with a retirement -> err_code_o=0, retire_cnt_o=1.
- rst_n pulsed mid-stream, then first order 7 -> ORDER set.
